// File: rtl/systolic_gemm_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : shared FSM encoding and sizing helpers for the GEMM tile
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Extra enabled steps needed after the last beat for it to reach PE(H-1,W-1).
  function automatic int flush_len(input int h, input int w);
    return h + w - 2;
  endfunction

  // Bits needed to index n distinct values, never fewer than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_gemm_tile_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_tile_if
// Brief    : control, operand-stream and result-stream bundle of the GEMM tile
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_gemm_tile_if
  import systolic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int K_MAX      = 256
);
  localparam int c_KW = idx_width(K_MAX + 1);
  localparam int c_RW = idx_width(ARR_HEIGHT);

  logic                            i_start;
  logic [c_KW-1:0]                 i_k_len;
  logic                            i_in_valid;
  logic                            o_in_ready;
  logic [ARR_HEIGHT*WIDTH-1:0]     i_in_a;
  logic [ARR_WIDTH*WIDTH-1:0]      i_in_b;
  logic                            o_out_valid;
  logic                            i_out_ready;
  logic [ARR_WIDTH*ACC_WIDTH-1:0]  o_out_row;
  logic [c_RW-1:0]                 o_out_row_idx;
  logic                            o_busy;
  logic                            o_done;

  modport slave (
    input  i_start, i_k_len, i_in_valid, i_in_a, i_in_b, i_out_ready,
    output o_in_ready, o_out_valid, o_out_row, o_out_row_idx, o_busy, o_done
  );

  modport master (
    output i_start, i_k_len, i_in_valid, i_in_a, i_in_b, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_row, o_out_row_idx, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/systolic_gemm_tile_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mac_pe
// Brief    : enable-gated MAC cell forwarding a east and b south
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mac_pe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [WIDTH-1:0]     o_a,
  output logic [WIDTH-1:0]     o_b,
  output logic [ACC_WIDTH-1:0] o_acc
);
  localparam int   c_EXT_W = ACC_WIDTH - WIDTH;
  localparam logic c_SX    = (SIGNED != 0);

  logic [ACC_WIDTH-1:0] w_a_ext;
  logic [ACC_WIDTH-1:0] w_b_ext;
  logic [ACC_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;

  // Since ACC_WIDTH >= 2*WIDTH, multiplying the extended operands modulo
  // 2^ACC_WIDTH equals the extended full-width product.
  assign w_a_ext = {{c_EXT_W{c_SX & i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{c_EXT_W{c_SX & i_b[WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
      r_a   <= i_a;
      r_b   <= i_b;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_gemm_tile.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_tile
// Brief    : self-sequencing output-stationary systolic GEMM tile
// Revision : 1.0 - initial release
// ============================================================================
module systolic_gemm_tile
  import systolic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int K_MAX      = 256,
  parameter int SIGNED     = 1
) (
  input  logic                clk,
  input  logic                reset,
  systolic_gemm_tile_if.slave bus
);
  localparam int c_KW = idx_width(K_MAX + 1);
  localparam int c_RW = idx_width(ARR_HEIGHT);
  localparam int c_FL = flush_len(ARR_HEIGHT, ARR_WIDTH);
  localparam int c_FW = idx_width(c_FL + 1);
  localparam int c_NP = ARR_HEIGHT * ARR_WIDTH;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [c_KW-1:0]                r_k_len;
  logic [c_KW-1:0]                r_beat;
  logic [c_KW-1:0]                w_k_sat;
  logic [c_FW-1:0]                r_flush;
  logic [c_RW-1:0]                r_row;
  logic                           r_done;
  logic                           w_beat;
  logic                           w_en;
  logic                           w_clr;
  logic                           w_row_acc;
  logic                           w_done_set;
  logic [ARR_HEIGHT*WIDTH-1:0]    w_a_skew;
  logic [ARR_WIDTH*WIDTH-1:0]     w_b_skew;
  logic [c_NP*WIDTH-1:0]          w_a_out;
  logic [c_NP*WIDTH-1:0]          w_b_out;
  logic [c_NP*ACC_WIDTH-1:0]      w_acc;
  logic [ARR_WIDTH*ACC_WIDTH-1:0] w_out_row;
  logic [ARR_HEIGHT*WIDTH-1:0]    w_unused_a;
  logic [ARR_WIDTH*WIDTH-1:0]     w_unused_b;

  assign w_k_sat = (bus.i_k_len > c_KW'(K_MAX)) ? c_KW'(K_MAX) : bus.i_k_len;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_en        = 1'b0;
    w_clr       = 1'b0;
    w_row_acc   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = (w_k_sat == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        w_beat = bus.i_in_valid;
        w_en   = w_beat;
        if (w_beat && (r_beat == r_k_len - c_KW'(1)))
          w_state_nxt = (c_FL == 0) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        w_en = 1'b1;
        if (r_flush == c_FW'(c_FL - 1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_row_acc = bus.i_out_ready;
        if (w_row_acc && (r_row == c_RW'(ARR_HEIGHT - 1))) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k_len <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_clr) begin
        r_k_len <= w_k_sat;
        r_beat  <= '0;
        r_flush <= '0;
        r_row   <= '0;
      end
      if (w_beat)            r_beat  <= r_beat + c_KW'(1);
      if (r_state == FLUSH)  r_flush <= r_flush + c_FW'(1);
      if (w_row_acc)         r_row   <= w_done_set ? '0 : r_row + c_RW'(1);
    end
  end

  // Outside LOAD the lanes carry zeros, which is what FLUSH injects.
  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_skew_a
    logic [WIDTH-1:0] w_lane;
    assign w_lane = (r_state == LOAD) ? bus.i_in_a[i*WIDTH +: WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign w_a_skew[i*WIDTH +: WIDTH] = w_lane;
    end else begin : g_delay
      logic [WIDTH-1:0] r_sh [i];
      always_ff @(posedge clk) begin
        if (reset || w_clr) begin
          for (int s = 0; s < i; s++) r_sh[s] <= '0;
        end else if (w_en) begin
          r_sh[0] <= w_lane;
          for (int s = 1; s < i; s++) r_sh[s] <= r_sh[s-1];
        end
      end
      assign w_a_skew[i*WIDTH +: WIDTH] = r_sh[i-1];
    end
  end

  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_skew_b
    logic [WIDTH-1:0] w_lane;
    assign w_lane = (r_state == LOAD) ? bus.i_in_b[j*WIDTH +: WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign w_b_skew[j*WIDTH +: WIDTH] = w_lane;
    end else begin : g_delay
      logic [WIDTH-1:0] r_sh [j];
      always_ff @(posedge clk) begin
        if (reset || w_clr) begin
          for (int s = 0; s < j; s++) r_sh[s] <= '0;
        end else if (w_en) begin
          r_sh[0] <= w_lane;
          for (int s = 1; s < j; s++) r_sh[s] <= r_sh[s-1];
        end
      end
      assign w_b_skew[j*WIDTH +: WIDTH] = r_sh[j-1];
    end
  end

  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_row
    for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_col
      localparam int c_P = i * ARR_WIDTH + j;
      logic [WIDTH-1:0] w_pa;
      logic [WIDTH-1:0] w_pb;
      if (j == 0) begin : g_a_edge
        assign w_pa = w_a_skew[i*WIDTH +: WIDTH];
      end else begin : g_a_fwd
        assign w_pa = w_a_out[(c_P-1)*WIDTH +: WIDTH];
      end
      if (i == 0) begin : g_b_edge
        assign w_pb = w_b_skew[j*WIDTH +: WIDTH];
      end else begin : g_b_fwd
        assign w_pb = w_b_out[(c_P-ARR_WIDTH)*WIDTH +: WIDTH];
      end
      systolic_mac_pe #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_a   (w_pa),
        .i_b   (w_pb),
        .o_a   (w_a_out[c_P*WIDTH +: WIDTH]),
        .o_b   (w_b_out[c_P*WIDTH +: WIDTH]),
        .o_acc (w_acc[c_P*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

  // Operands leaving the east and south edges have no consumer.
  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_east_edge
    assign w_unused_a[i*WIDTH +: WIDTH] = w_a_out[(i*ARR_WIDTH+ARR_WIDTH-1)*WIDTH +: WIDTH];
  end
  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_south_edge
    assign w_unused_b[j*WIDTH +: WIDTH] = w_b_out[((ARR_HEIGHT-1)*ARR_WIDTH+j)*WIDTH +: WIDTH];
  end

  always_comb begin
    w_out_row = '0;
    if (r_state == DRAIN) begin
      for (int j = 0; j < ARR_WIDTH; j++)
        w_out_row[j*ACC_WIDTH +: ACC_WIDTH] =
          w_acc[(int'(r_row)*ARR_WIDTH + j)*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign bus.o_in_ready    = (r_state == LOAD);
  assign bus.o_out_valid   = (r_state == DRAIN);
  assign bus.o_out_row     = w_out_row;
  assign bus.o_out_row_idx = r_row;
  assign bus.o_busy        = (r_state != IDLE);
  assign bus.o_done        = r_done;

endmodule
`default_nettype wire
